// File: rtl/regfile_dbg_port.sv
// Debug-side initiator for the register file: halts the core, performs a read, a write
// or a full dump through the regfile ports, and returns results on a valid/ready channel.
//
// state     | meaning
// IDLE      | cmd_ready high, waiting for a command
// HALT_WAIT | core_halt raised, waiting for core_halted or timeout
// EXEC      | one cycle driving the regfile ports, capture result
// RESP      | response presented until rsp_ready
module regfile_dbg_port #(
   parameter int XLEN         = 32,
   parameter int NREGS        = 32,
   parameter int AW           = $clog2(NREGS),
   parameter int HALT_TIMEOUT = 16
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            cmd_valid,
   output logic            cmd_ready,
   input  logic [1:0]      cmd_op,
   input  logic [AW-1:0]   cmd_addr,
   input  logic [XLEN-1:0] cmd_wdata,
   output logic            rsp_valid,
   input  logic            rsp_ready,
   output logic [XLEN-1:0] rsp_data,
   output logic [AW-1:0]   rsp_addr,
   output logic            rsp_last,
   output logic            rsp_err,
   output logic            core_halt,
   input  logic            core_halted,
   output logic [AW-1:0]   rf_ra,
   input  logic [XLEN-1:0] rf_rd,
   output logic [AW-1:0]   rf_wa,
   output logic [XLEN-1:0] rf_wd,
   output logic            rf_we
);

   localparam int TW = $clog2(HALT_TIMEOUT + 1);
   localparam logic [1:0] OP_RD   = 2'b00;
   localparam logic [1:0] OP_WR   = 2'b01;
   localparam logic [1:0] OP_DUMP = 2'b10;
   localparam logic [1:0] OP_ILL  = 2'b11;

   typedef enum logic [1:0] {IDLE, HALT_WAIT, EXEC, RESP} state_t;

   state_t            state_q;
   logic [1:0]        op_q;
   logic [AW-1:0]     ptr_q;
   logic [XLEN-1:0]   wdata_q;
   logic [TW-1:0]     timer_q;
   logic              core_halt_q;
   logic              rf_we_q;
   logic              rsp_valid_q;
   logic [XLEN-1:0]   rsp_data_q;
   logic              rsp_last_q;
   logic              rsp_err_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         op_q        <= OP_RD;
         ptr_q       <= '0;
         wdata_q     <= '0;
         timer_q     <= '0;
         core_halt_q <= 1'b0;
         rf_we_q     <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= '0;
         rsp_last_q  <= 1'b0;
         rsp_err_q   <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (cmd_valid) begin
                  op_q    <= cmd_op;
                  wdata_q <= cmd_wdata;
                  ptr_q   <= (cmd_op == OP_DUMP) ? '0 : cmd_addr;
                  timer_q <= '0;
                  if (cmd_op == OP_ILL) begin
                     rsp_valid_q <= 1'b1;
                     rsp_err_q   <= 1'b1;
                     rsp_last_q  <= 1'b1;
                     rsp_data_q  <= '0;
                     state_q     <= RESP;
                  end else begin
                     core_halt_q <= 1'b1;
                     state_q     <= HALT_WAIT;
                  end
               end
            end
            HALT_WAIT: begin
               if (core_halted) begin
                  // Registered so the write pulse coincides exactly with EXEC.
                  rf_we_q <= (op_q == OP_WR);
                  state_q <= EXEC;
               end else if (timer_q == TW'(HALT_TIMEOUT - 1)) begin
                  rsp_valid_q <= 1'b1;
                  rsp_err_q   <= 1'b1;
                  rsp_last_q  <= 1'b1;
                  rsp_data_q  <= '0;
                  state_q     <= RESP;
               end else begin
                  timer_q <= timer_q + TW'(1);
               end
            end
            EXEC: begin
               rf_we_q     <= 1'b0;
               rsp_data_q  <= (op_q == OP_WR) ? wdata_q : rf_rd;
               rsp_err_q   <= 1'b0;
               rsp_last_q  <= (op_q != OP_DUMP) || (ptr_q == AW'(NREGS - 1));
               rsp_valid_q <= 1'b1;
               state_q     <= RESP;
            end
            RESP: begin
               if (rsp_ready) begin
                  rsp_valid_q <= 1'b0;
                  // Core stays halted across the whole dump; a timed-out dump ends here.
                  if (op_q == OP_DUMP && !rsp_err_q && ptr_q != AW'(NREGS - 1)) begin
                     ptr_q   <= ptr_q + AW'(1);
                     state_q <= EXEC;
                  end else begin
                     core_halt_q <= 1'b0;
                     state_q     <= IDLE;
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign cmd_ready = (state_q == IDLE);
   assign rsp_valid = rsp_valid_q;
   assign rsp_data  = rsp_data_q;
   assign rsp_addr  = ptr_q;
   assign rsp_last  = rsp_last_q;
   assign rsp_err   = rsp_err_q;
   assign core_halt = core_halt_q;
   assign rf_ra     = ptr_q;
   assign rf_wa     = ptr_q;
   assign rf_wd     = wdata_q;
   assign rf_we     = rf_we_q;

endmodule

// File: tb/tb_regfile_dbg_port.sv
// Bench for regfile_dbg_port: scoreboard of expected responses built from a register-array
// reference model, with a monitor that consumes responses and regfile write pulses.
module tb_regfile_dbg_port;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic [1:0]  cmd_op = 2'b00;
   logic [4:0]  cmd_addr = '0;
   logic [31:0] cmd_wdata = '0;
   logic        rsp_valid;
   logic        rsp_ready = 1'b0;
   logic [31:0] rsp_data;
   logic [4:0]  rsp_addr;
   logic        rsp_last;
   logic        rsp_err;
   logic        core_halt;
   logic        core_halted = 1'b0;
   logic [4:0]  rf_ra;
   logic [31:0] rf_rd;
   logic [4:0]  rf_wa;
   logic [31:0] rf_wd;
   logic        rf_we;

   always #5 clk = ~clk;

   regfile_dbg_port dut (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
      .rsp_addr(rsp_addr), .rsp_last(rsp_last), .rsp_err(rsp_err),
      .core_halt(core_halt), .core_halted(core_halted),
      .rf_ra(rf_ra), .rf_rd(rf_rd), .rf_wa(rf_wa), .rf_wd(rf_wd), .rf_we(rf_we)
   );

   // Environment register file: combinational read, synchronous write, x0 hardwired.
   logic [31:0] rf_mem [32] = '{default: '0};
   always @(posedge clk) if (rf_we && rf_wa != 5'd0) rf_mem[rf_wa] <= rf_wd;
   assign rf_rd = rf_mem[rf_ra];

   typedef struct {
      logic [31:0] data;
      logic [4:0]  addr;
      logic        last;
      logic        err;
      logic        halt;
   } exp_t;
   typedef struct {
      logic [4:0]  a;
      logic [31:0] d;
   } wr_t;

   exp_t        exp_q[$];
   wr_t         wr_q[$];
   logic [31:0] ref_regs [32];
   int          n_cmp = 0;
   int          n_bad = 0;
   int          halt_mode = 0;   // 0 halted always, 1 follows core_halt after delay, 2 never
   int          halt_dly = 1;
   int          ready_mode = 2;  // 0 random, 1 toggle, 2 always

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   // Core model: reports halted according to the selected behaviour.
   initial begin
      logic [15:0] hist;
      hist = '0;
      forever begin
         @(negedge clk);
         hist = {hist[14:0], core_halt};
         case (halt_mode)
            0:       core_halted = 1'b1;
            1:       core_halted = hist[halt_dly];
            default: core_halted = 1'b0;
         endcase
      end
   end

   // Monitor: drives rsp_ready, checks every response handshake and every write pulse.
   initial begin
      exp_t e;
      wr_t  w;
      forever begin
         @(negedge clk);
         case (ready_mode)
            0:       rsp_ready = 1'($urandom_range(0, 1));
            1:       rsp_ready = !rsp_ready;
            default: rsp_ready = 1'b1;
         endcase
         #1;
         if (rf_we) begin
            n_cmp++;
            if (wr_q.size() == 0) begin
               n_bad++;
               $display("FAIL wr_pulse: unexpected rf_we wa=%0d wd=%0h", rf_wa, rf_wd);
            end else begin
               w = wr_q.pop_front();
               if (rf_wa !== w.a || rf_wd !== w.d) begin
                  n_bad++;
                  $display("FAIL wr_pulse: got wa=%0d wd=%0h want wa=%0d wd=%0h",
                           rf_wa, rf_wd, w.a, w.d);
               end
            end
         end
         if (rsp_valid && rsp_ready) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
               n_bad++;
               $display("FAIL rsp: unexpected response addr=%0d data=%0h", rsp_addr, rsp_data);
            end else begin
               e = exp_q.pop_front();
               if (rsp_data !== e.data || rsp_addr !== e.addr || rsp_last !== e.last ||
                   rsp_err !== e.err || core_halt !== e.halt) begin
                  n_bad++;
                  $display("FAIL rsp: got d=%0h a=%0d l=%0b e=%0b h=%0b want d=%0h a=%0d l=%0b e=%0b h=%0b",
                           rsp_data, rsp_addr, rsp_last, rsp_err, core_halt,
                           e.data, e.addr, e.last, e.err, e.halt);
               end
            end
         end
      end
   end

   task automatic push_exp(input logic [31:0] d, input logic [4:0] a, input logic l,
                           input logic er, input logic h);
      exp_t e;
      e.data = d; e.addr = a; e.last = l; e.err = er; e.halt = h;
      exp_q.push_back(e);
   endtask

   task automatic issue(input logic [1:0] op, input logic [4:0] a, input logic [31:0] d,
                        input int hmode, input int hdly, input bit expect_rsp);
      int t;
      wr_t w;
      @(negedge clk);
      cmd_valid = 1'b1; cmd_op = op; cmd_addr = a; cmd_wdata = d;
      t = 0;
      while (!cmd_ready && t < 3000) begin
         @(negedge clk);
         t++;
      end
      if (!cmd_ready) begin
         chk("cmd_accept_timeout", 64'(cmd_ready), 64'd1);
         cmd_valid = 1'b0;
         return;
      end
      halt_mode = hmode;
      halt_dly  = hdly;
      if (expect_rsp) begin
         if (op == 2'b11)
            push_exp(32'd0, a, 1'b1, 1'b1, 1'b0);
         else if (hmode == 2)
            push_exp(32'd0, (op == 2'b10) ? 5'd0 : a, 1'b1, 1'b1, 1'b1);
         else if (op == 2'b00)
            push_exp(ref_regs[a], a, 1'b1, 1'b0, 1'b1);
         else if (op == 2'b01) begin
            push_exp(d, a, 1'b1, 1'b0, 1'b1);
            w.a = a; w.d = d;
            wr_q.push_back(w);
            if (a != 5'd0) ref_regs[a] = d;
         end else
            for (int i = 0; i < 32; i++)
               push_exp(ref_regs[i], 5'(i), (i == 31), 1'b0, 1'b1);
      end
      @(negedge clk);
      cmd_valid = 1'b0;
   endtask

   // Called at the negedge following the accept cycle; returns cycles from accept to rsp_valid.
   task automatic measure_lat(output int n);
      n = 1;
      while (!rsp_valid && n < 60) begin
         @(negedge clk);
         n++;
      end
   endtask

   task automatic wait_idle();
      int t;
      t = 0;
      while ((exp_q.size() != 0 || !cmd_ready) && t < 5000) begin
         @(negedge clk);
         t++;
      end
      chk("idle", 64'(exp_q.size() == 0 && cmd_ready), 64'd1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat;
      for (int i = 0; i < 32; i++) ref_regs[i] = '0;

      repeat (3) @(negedge clk);
      #1;
      chk("rst_core_halt", 64'(core_halt), 64'd0);
      chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
      chk("rst_rf_we", 64'(rf_we), 64'd0);
      chk("rst_rsp_data", 64'(rsp_data), 64'd0);
      chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);
      @(negedge clk);
      rst_n = 1'b1;

      ready_mode = 2;
      issue(2'b01, 5'd1, 32'hAAAABBBB, 0, 1, 1);
      wait_idle();
      issue(2'b01, 5'd5, 32'h11112222, 0, 1, 1);
      wait_idle();
      issue(2'b00, 5'd1, 32'h0, 0, 1, 1);
      measure_lat(lat);
      chk("read_latency", 64'(lat), 64'd3);
      wait_idle();

      issue(2'b01, 5'd0, 32'h12345678, 0, 1, 1);
      wait_idle();
      issue(2'b00, 5'd0, 32'h0, 0, 1, 1);
      wait_idle();

      ready_mode = 1;
      issue(2'b10, 5'd9, 32'h0, 0, 1, 1);
      wait_idle();
      chk("dump_halt_release", 64'(core_halt), 64'd0);

      ready_mode = 2;
      issue(2'b01, 5'd7, 32'h00000055, 2, 1, 1);
      measure_lat(lat);
      chk("timeout_latency", 64'(lat), 64'd17);
      wait_idle();
      chk("timeout_halt_release", 64'(core_halt), 64'd0);
      chk("timeout_x7", 64'(rf_mem[7]), 64'd0);

      issue(2'b11, 5'd9, 32'h0, 0, 1, 1);
      measure_lat(lat);
      chk("illegal_latency", 64'(lat), 64'd1);
      chk("illegal_no_halt", 64'(core_halt), 64'd0);
      wait_idle();

      issue(2'b01, 5'd5, 32'hDEADBEEF, 2, 1, 0);
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("midrst_core_halt", 64'(core_halt), 64'd0);
      chk("midrst_rsp_valid", 64'(rsp_valid), 64'd0);
      chk("midrst_rf_we", 64'(rf_we), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("midrst_cmd_ready", 64'(cmd_ready), 64'd1);
      chk("midrst_x5", 64'(rf_mem[5]), 64'h11112222);
      issue(2'b00, 5'd5, 32'h0, 0, 1, 1);
      wait_idle();

      for (int k = 0; k < 40; k++) begin
         int r, m;
         logic [1:0] op;
         r = $urandom_range(0, 9);
         op = (r < 4) ? 2'b00 : (r < 7) ? 2'b01 : (r < 8) ? 2'b10 : (r < 9) ? 2'b11 : 2'b01;
         r = $urandom_range(0, 9);
         m = (r < 6) ? 0 : (r < 9) ? 1 : 2;
         ready_mode = $urandom_range(0, 2);
         issue(op, 5'($urandom_range(0, 31)), $urandom, m, $urandom_range(1, 8), 1);
      end
      wait_idle();
      repeat (3) @(negedge clk);
      chk("writes_drained", 64'(wr_q.size()), 64'd0);
      chk("rsp_drained", 64'(exp_q.size()), 64'd0);
      chk("final_halt_release", 64'(core_halt), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
